// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 comb reads, 2 prioritised writes, bulk-clear engine.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module reg_file_mp #(
    parameter int PW      = 3,
    parameter int DW      = 8,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          wr_en0,
    input  logic [PW-1:0] wr_addr0,
    input  logic [DW-1:0] dat_in0,
    input  logic          wr_en1,
    input  logic [PW-1:0] wr_addr1,
    input  logic [DW-1:0] dat_in1,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam int DEPTH = 1 << PW;
    localparam bit ZR    = (ZERO_R0 != 0);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          clr_done_q, clr_done_d;
    logic [DW-1:0] core_q [DEPTH];
    logic [DW-1:0] core_d [DEPTH];

    // Read one port: stored data, optional bypass, forced zero on entry 0.
    function automatic logic [DW-1:0] rd_port(input logic [PW-1:0] a);
        logic [DW-1:0] r;
        r = core_q[a];
`ifdef RF_BYPASS_EN
        if (state_q == IDLE) begin
            if (wr_en1 && wr_addr1 == a) r = dat_in1;
            else if (wr_en0 && wr_addr0 == a) r = dat_in0;
        end
`endif
        if (ZR && a == '0) r = '0;
        return r;
    endfunction

    assign datA_out = rd_port(rd_addrA);
    assign datB_out = rd_port(rd_addrB);
    assign busy     = busy_q;
    assign clr_done = clr_done_q;
    assign wr_drop  = busy_q & (wr_en0 | wr_en1);

    // Next-state: user writes in IDLE, one entry cleared per edge in CLEAR.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        core_d  = core_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en0 && !(ZR && wr_addr0 == '0))
                    core_d[wr_addr0] = dat_in0;
                if (wr_en1 && !(ZR && wr_addr1 == '0))
                    core_d[wr_addr1] = dat_in1;
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                core_d[idx_q] = '0;
                idx_d         = idx_q + PW'(1);
                if (idx_q == PW'(DEPTH - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        clr_done_d = (state_d == DONE);
    end

    // State, index, registered status outputs and storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                core_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            for (int i = 0; i < DEPTH; i++)
                core_q[i] <= core_d[i];
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: two instances (ZERO_R0=0 and ZERO_R0=1)
// driven in parallel and compared against an array/counter model.
module tb_reg_file_mp;

    logic       clk, rst_n;
    logic [2:0] rd_addrA, rd_addrB, wr_addr0, wr_addr1;
    logic [7:0] dat_in0, dat_in1;
    logic       wr_en0, wr_en1, clr_req;
    logic [7:0] a0, b0, a1, b1;
    logic       busy0, busy1, done0, done1, drop0, drop1;

    logic [7:0] m0 [8];
    logic [7:0] m1 [8];
    int age;
    int cmp = 0;
    int err = 0;

    reg_file_mp #(.PW(3), .DW(8), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(a0), .datB_out(b0),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .dat_in0(dat_in0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .dat_in1(dat_in1),
        .clr_req(clr_req), .busy(busy0), .clr_done(done0), .wr_drop(drop0)
    );

    reg_file_mp #(.PW(3), .DW(8), .ZERO_R0(1)) u_dutz (
        .clk(clk), .rst_n(rst_n),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(a1), .datB_out(b1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .dat_in0(dat_in0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .dat_in1(dat_in1),
        .clr_req(clr_req), .busy(busy1), .clr_done(done1), .wr_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // age < 0: idle; 0..7: clearing entry 'age' next edge; 8: done cycle.
    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 8'h00;
            m1[i] = 8'h00;
        end
        age = -1;
    endtask

    task automatic model_edge();
        if (age < 0) begin
            if (wr_en0) begin
                m0[wr_addr0] = dat_in0;
                if (wr_addr0 != 3'd0) m1[wr_addr0] = dat_in0;
            end
            if (wr_en1) begin
                m0[wr_addr1] = dat_in1;
                if (wr_addr1 != 3'd0) m1[wr_addr1] = dat_in1;
            end
            if (clr_req) age = 0;
        end else if (age < 8) begin
            m0[age] = 8'h00;
            m1[age] = 8'h00;
            age++;
        end else begin
            age = -1;
        end
    endtask

    function automatic logic [7:0] exp_rd(input bit z, input logic [2:0] a);
        if (z && a == 3'd0) return 8'h00;
`ifdef RF_BYPASS_EN
        if (age < 0) begin
            if (wr_en1 && wr_addr1 == a) return dat_in1;
            if (wr_en0 && wr_addr0 == a) return dat_in0;
        end
`endif
        return z ? m1[a] : m0[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en0 = 0; wr_en1 = 0; clr_req = 0;
        wr_addr0 = 0; wr_addr1 = 0; dat_in0 = 0; dat_in1 = 0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            wr_en0 = 1; wr_addr0 = 3'(i);
            dat_in0 = 8'(8'h80 | $urandom_range(1, 127));
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        fill_all();
        #2 rst_n = 0;
        #1;
        cmp++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            err++;
            $display("FAIL reset_busy got=%b/%b exp=0", busy0, busy1);
        end
        for (int a = 0; a < 8; a++) begin
            rd_addrA = 3'(a); rd_addrB = 3'(7 - a);
            #1;
            cmp++;
            if ({a0, b0, a1, b1} !== 32'h0) begin
                err++;
                $display("FAIL reset_read addr=%0d got=%h exp=0",
                         a, {a0, b0, a1, b1});
            end
        end
        model_reset();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_dual_write();
        wr_en0 = 1; wr_addr0 = 3'd2; dat_in0 = 8'h11;
        wr_en1 = 1; wr_addr1 = 3'd5; dat_in1 = 8'hA5;
        tick();
        idle_inputs();
        rd_addrA = 3'd2; rd_addrB = 3'd5;
        #1;
        cmp++;
        if (a0 !== 8'h11 || b0 !== 8'hA5) begin
            err++;
            $display("FAIL dual_diff got=%h,%h exp=11,a5", a0, b0);
        end
        wr_en0 = 1; wr_addr0 = 3'd3; dat_in0 = 8'h22;
        wr_en1 = 1; wr_addr1 = 3'd3; dat_in1 = 8'h33;
        tick();
        idle_inputs();
        rd_addrA = 3'd3; rd_addrB = 3'd3;
        #1;
        cmp++;
        if (a0 !== 8'h33 || b1 !== 8'h33) begin
            err++;
            $display("FAIL dual_same got=%h,%h exp=33", a0, b1);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] old, exp;
        old = m0[4];
        wr_en1 = 1; wr_addr1 = 3'd4; dat_in1 = 8'h5C;
        rd_addrA = 3'd4; rd_addrB = 3'd2;
        #1;
`ifdef RF_BYPASS_EN
        exp = 8'h5C;
`else
        exp = old;
`endif
        cmp++;
        if (a0 !== exp || a1 !== exp) begin
            err++;
            $display("FAIL bypass_same got=%h,%h exp=%h", a0, a1, exp);
        end
        tick();
        idle_inputs();
        #1;
        cmp++;
        if (a0 !== 8'h5C) begin
            err++;
            $display("FAIL bypass_after got=%h exp=5c", a0);
        end
    endtask

    task automatic test_zero_reg();
        wr_en0 = 1; wr_addr0 = 3'd0; dat_in0 = 8'hFF;
        rd_addrA = 3'd0; rd_addrB = 3'd0;
        #1;
        cmp++;
        if (a1 !== 8'h00 || b1 !== 8'h00) begin
            err++;
            $display("FAIL zero_same got=%h,%h exp=0", a1, b1);
        end
        tick();
        idle_inputs();
        #1;
        cmp++;
        if (a0 !== 8'hFF || a1 !== 8'h00) begin
            err++;
            $display("FAIL zero_reg got=%h,%h exp=ff,00", a0, a1);
        end
    endtask

    task automatic test_bulk_clear();
        int nbusy, ndone;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        nbusy = 0; ndone = 0;
        for (int k = 0; k < 14; k++) begin
            idle_inputs();
            if (k == 3) begin
                wr_en1 = 1; wr_addr1 = 3'd1; dat_in1 = 8'h77;
            end
            if (k == 5 || k == 8) clr_req = 1;
            rd_addrA = 3'(k); rd_addrB = 3'(k + 4);
            #1;
            if (busy0) nbusy++;
            if (done0) ndone++;
            cmp++;
            if (busy0 !== (age >= 0) || busy1 !== (age >= 0)) begin
                err++;
                $display("FAIL clr_busy k=%0d got=%b/%b exp=%b",
                         k, busy0, busy1, age >= 0);
            end
            cmp++;
            if (done0 !== (age == 8) || done1 !== (age == 8)) begin
                err++;
                $display("FAIL clr_done k=%0d got=%b/%b exp=%b",
                         k, done0, done1, age == 8);
            end
            cmp++;
            if (drop0 !== ((age >= 0) && wr_en1)) begin
                err++;
                $display("FAIL clr_drop k=%0d got=%b exp=%b",
                         k, drop0, (age >= 0) && wr_en1);
            end
            cmp++;
            if (a0 !== exp_rd(0, rd_addrA) || b0 !== exp_rd(0, rd_addrB)) begin
                err++;
                $display("FAIL clr_read k=%0d got=%h,%h exp=%h,%h", k, a0, b0,
                         exp_rd(0, rd_addrA), exp_rd(0, rd_addrB));
            end
            tick();
        end
        idle_inputs();
        cmp++;
        if (nbusy !== 9 || ndone !== 1) begin
            err++;
            $display("FAIL clr_count got=%0d/%0d exp=9/1", nbusy, ndone);
        end
        for (int a = 0; a < 8; a++) begin
            rd_addrA = 3'(a); rd_addrB = 3'(a);
            #1;
            cmp++;
            if (a0 !== 8'h00 || b1 !== 8'h00) begin
                err++;
                $display("FAIL clr_zero addr=%0d got=%h,%h exp=0", a, a0, b1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int ndone;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (3) tick();
        #2 rst_n = 0;
        #1;
        cmp++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0) begin
            err++;
            $display("FAIL midrst_busy got=%b/%b/%b exp=0", busy0, busy1, done0);
        end
        model_reset();
        for (int a = 0; a < 8; a++) begin
            rd_addrA = 3'(a); rd_addrB = 3'(a);
            #1;
            cmp++;
            if (a0 !== 8'h00 || a1 !== 8'h00) begin
                err++;
                $display("FAIL midrst_read addr=%0d got=%h,%h exp=0", a, a0, a1);
            end
        end
        rst_n = 1;
        @(negedge clk);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (done0 || done1 || busy0) ndone++;
            tick();
        end
        cmp++;
        if (ndone !== 0) begin
            err++;
            $display("FAIL midrst_nodone got=%0d exp=0", ndone);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en0 = 1'($urandom_range(0, 1));
            wr_en1 = 1'($urandom_range(0, 1));
            wr_addr0 = 3'($urandom_range(0, 7));
            wr_addr1 = 3'($urandom_range(0, 7));
            dat_in0 = 8'($urandom);
            dat_in1 = 8'($urandom);
            rd_addrA = 3'($urandom_range(0, 7));
            rd_addrB = 3'($urandom_range(0, 7));
            clr_req = ($urandom_range(0, 39) == 0);
            #1;
            cmp++;
            if (a0 !== exp_rd(0, rd_addrA) || b0 !== exp_rd(0, rd_addrB)) begin
                err++;
                $display("FAIL rand_rd0 c=%0d got=%h,%h exp=%h,%h", c, a0, b0,
                         exp_rd(0, rd_addrA), exp_rd(0, rd_addrB));
            end
            cmp++;
            if (a1 !== exp_rd(1, rd_addrA) || b1 !== exp_rd(1, rd_addrB)) begin
                err++;
                $display("FAIL rand_rd1 c=%0d got=%h,%h exp=%h,%h", c, a1, b1,
                         exp_rd(1, rd_addrA), exp_rd(1, rd_addrB));
            end
            cmp++;
            if (busy0 !== (age >= 0) || done0 !== (age == 8) ||
                drop0 !== ((age >= 0) && (wr_en0 || wr_en1))) begin
                err++;
                $display("FAIL rand_stat c=%0d got=%b%b%b age=%0d",
                         c, busy0, done0, drop0, age);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        rd_addrA = 0; rd_addrB = 0;
        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
        test_reset();
        test_dual_write();
        test_bypass();
        test_zero_reg();
        test_bulk_clear();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
